// File: rtl/tc_pl_cap_gain_dac_seq.sv
// Multi-channel cap-gain DAC setup sequencer: latches per-channel gains
// and streams masked channel frames MSB byte first to the SPI TX engine.
module tc_pl_cap_gain_dac_seq #(
  parameter int unsigned CHN_NUM = 4,
  parameter int unsigned CAP0_12 = 32,
  parameter int unsigned GDAC0_0 = 24,
  parameter int unsigned SPI0_0  = 8,
  parameter logic [3:0]  CMD_WR  = 4'h3,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gset_en,
  input  logic [CHN_NUM-1:0]         gset_mask,
  input  logic [CHN_NUM*CAP0_12-1:0] gset_dac,
  output logic                       gset_busy,
  output logic                       gset_adc_cmpt,
  output logic                       gset_err,
  input  logic                       stx_idle,
  input  logic                       stx_dreq,
  output logic                       stx_valid,
  output logic [SPI0_0-1:0]          stx_data
);

  localparam int unsigned NB = GDAC0_0 / SPI0_0;
  localparam int unsigned CW = $clog2(CHN_NUM + 1);
  localparam int unsigned BW = $clog2(NB) + 1;
  localparam int unsigned TW = $clog2(TMO_CYC);
  localparam int unsigned LW = GDAC0_0 - 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT_IDLE,
    S_SEND,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [CHN_NUM-1:0]         mask_q;
  logic [CHN_NUM*CAP0_12-1:0] dac_q;
  logic [CW-1:0]              ch_q, ch_d;
  logic [BW-1:0]              bcnt_q, bcnt_d;
  logic [TW-1:0]              tmo_q;
  logic [GDAC0_0-1:0]         frame_q, frame_d;
  logic                       seen_q, seen_d;
  logic                       err_q, err_d;
  logic                       latch;

  logic [CAP0_12-1:0] cur_word;
  logic               cur_mask;
  logic               xfer;
  logic               tmo_hit;
  logic               last;
  logic               waiting;
  logic               unused_hi;

  always_comb begin
    cur_word = '0;
    cur_mask = 1'b0;
    for (int i = 0; i < int'(CHN_NUM); i++) begin
      if (ch_q == CW'(i)) begin
        cur_word = dac_q[i*CAP0_12 +: CAP0_12];
        cur_mask = mask_q[i];
      end
    end
  end

  // Only the low frame-payload bits of each gain word reach the DAC.
  assign unused_hi = ^cur_word[CAP0_12-1:LW];

  assign xfer    = (state_q == S_SEND) && stx_dreq;
  assign tmo_hit = tmo_q == TW'(TMO_CYC - 1);
  assign last    = bcnt_q == BW'(NB - 1);
  assign waiting = (state_q == S_WAIT_IDLE) ||
                   (state_q == S_SEND) ||
                   (state_q == S_WAIT_DONE);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bcnt_d  = bcnt_q;
    frame_d = frame_q;
    seen_d  = seen_q;
    err_d   = err_q;
    latch   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gset_en) begin
          latch   = 1'b1;
          err_d   = 1'b0;
          ch_d    = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (ch_q == CW'(CHN_NUM)) begin
          state_d = S_DONE;
        end else if (!cur_mask) begin
          ch_d = ch_q + CW'(1);
        end else begin
          frame_d = {CMD_WR, 4'(ch_q), cur_word[LW-1:0]};
          bcnt_d  = '0;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (stx_idle) begin
          state_d = S_SEND;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SEND: begin
        if (!stx_idle) seen_d = 1'b1;
        if (xfer) begin
          bcnt_d  = bcnt_q + BW'(1);
          frame_d = frame_q << SPI0_0;
          if (last) begin
            seen_d  = 1'b0;
            state_d = S_WAIT_DONE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!stx_idle) seen_d = 1'b1;
        if (seen_q && stx_idle) begin
          ch_d    = ch_q + CW'(1);
          state_d = S_SCAN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      dac_q   <= '0;
      ch_q    <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      frame_q <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      bcnt_q  <= bcnt_d;
      frame_q <= frame_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      if (latch) begin
        mask_q <= gset_mask;
        dac_q  <= gset_dac;
      end
      // Restart the wait budget on every state change and every byte.
      if ((state_d != state_q) || xfer || !waiting) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  assign gset_busy     = state_q != S_IDLE;
  assign gset_adc_cmpt = state_q == S_DONE;
  assign gset_err      = err_q;
  assign stx_valid     = state_q == S_SEND;
  assign stx_data      = frame_q[GDAC0_0-1 -: SPI0_0];

endmodule

// File: tb/tb_tc_pl_cap_gain_dac_seq.sv
// Bench for tc_pl_cap_gain_dac_seq: random gain words against a byte-stream
// reference model, with a simple SPI engine model driving the handshake.
module tb_tc_pl_cap_gain_dac_seq;

  localparam int CHN = 4;
  localparam int CAP = 32;
  localparam int GD  = 24;
  localparam int SP  = 8;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              gset_en;
  logic [CHN-1:0]    gset_mask;
  logic [CHN*CAP-1:0] gset_dac;
  logic              gset_busy;
  logic              gset_adc_cmpt;
  logic              gset_err;
  logic              stx_idle;
  logic              stx_dreq;
  logic              stx_valid;
  logic [SP-1:0]     stx_data;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int  valid_cycles = 0;
  bit  hold_busy = 0;
  int  stall_at = -1;
  int  stall_rem = 0;

  tc_pl_cap_gain_dac_seq #(
    .CHN_NUM(CHN),
    .CAP0_12(CAP),
    .GDAC0_0(GD),
    .SPI0_0 (SP),
    .CMD_WR (4'h3),
    .TMO_CYC(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gset_en      (gset_en),
    .gset_mask    (gset_mask),
    .gset_dac     (gset_dac),
    .gset_busy    (gset_busy),
    .gset_adc_cmpt(gset_adc_cmpt),
    .gset_err     (gset_err),
    .stx_idle     (stx_idle),
    .stx_dreq     (stx_dreq),
    .stx_valid    (stx_valid),
    .stx_data     (stx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each enabled channel yields cmd/index nibble then the low
  // 16 bits of its word, most significant byte first.
  task automatic build_exp(input logic [CHN-1:0] mask,
                           input logic [CHN*CAP-1:0] dac);
    longint w;
    longint f;
    exp_q.delete();
    for (int i = 0; i < CHN; i++) begin
      if (mask[i]) begin
        w = longint'(dac[i*CAP +: CAP]);
        f = 3 * 1048576 + i * 65536 + (w % 65536);
        exp_q.push_back(8'(f / 65536));
        exp_q.push_back(8'((f / 256) % 256));
        exp_q.push_back(8'(f % 256));
      end
    end
  endtask

  task automatic engine();
    logic [7:0] pdata;
    bit pnox;
    bit d;
    int tail;
    pdata = '0;
    pnox = 0;
    tail = 0;
    forever begin
      @(negedge clk);
      if (rst && stx_valid) valid_cycles++;
      if (!rst) begin
        stx_dreq = 1'b0;
        stx_idle = 1'b1;
        tail = 0;
        pnox = 0;
      end else if (hold_busy) begin
        stx_dreq = 1'b0;
        stx_idle = 1'b0;
        tail = 1;
        pnox = 0;
      end else begin
        if (pnox) begin
          check("hold_valid", 32'(stx_valid), 32'd1);
          check("hold_data", 32'(stx_data), 32'(pdata));
        end
        d = 1;
        if (got.size() == stall_at && stall_rem > 0) begin
          d = 0;
          stall_rem--;
        end
        stx_dreq = d;
        if (stx_valid && d) begin
          got.push_back(stx_data);
          stx_idle = 1'b0;
          tail = 4;
        end else if (!stx_valid && tail > 0) begin
          tail--;
          if (tail == 0) stx_idle = 1'b1;
        end
        pnox = stx_valid && !d;
        pdata = stx_data;
      end
    end
  endtask

  task automatic start(input logic [CHN-1:0] mask,
                       input logic [CHN*CAP-1:0] dac);
    @(negedge clk);
    gset_mask = mask;
    gset_dac = dac;
    gset_en = 1'b1;
    @(negedge clk);
    gset_en = 1'b0;
  endtask

  task automatic run(input logic [CHN-1:0] mask,
                     input logic [CHN*CAP-1:0] dac,
                     input int exp_k, input bit exp_err, input bit inject);
    int k;
    got.delete();
    valid_cycles = 0;
    if (exp_err) exp_q.delete();
    else build_exp(mask, dac);
    start(mask, dac);
    check("busy_on", 32'(gset_busy), 32'd1);
    check("err_clr", 32'(gset_err), 32'd0);
    k = 1;
    while (gset_adc_cmpt !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      if (inject && k == 3) begin
        gset_en = 1'b1;
        gset_dac = ~dac;
        gset_mask = ~mask;
      end
      if (inject && k == 4) gset_en = 1'b0;
    end
    check("cmpt_seen", 32'(gset_adc_cmpt), 32'd1);
    if (exp_k > 0) check("cmpt_lat", 32'(k), 32'(exp_k));
    check("err_at_cmpt", 32'(gset_err), 32'(exp_err));
    @(negedge clk);
    check("cmpt_pulse", 32'(gset_adc_cmpt), 32'd0);
    check("busy_off", 32'(gset_busy), 32'd0);
    if (inject) begin
      repeat (8) @(negedge clk);
      check("no_requeue", 32'(gset_busy), 32'd0);
    end
    check("byte_cnt", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check("byte", (i < got.size()) ? 32'(got[i]) : 32'hxx,
            32'(exp_q[i]));
    end
    if (exp_q.size() == 0) check("no_valid", 32'(valid_cycles), 32'd0);
  endtask

  function automatic logic [CHN*CAP-1:0] rand_dac();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [CHN*CAP-1:0] d;
    int n;
    rst = 1'b0;
    gset_en = 1'b0;
    gset_mask = '0;
    gset_dac = '0;
    stx_idle = 1'b1;
    stx_dreq = 1'b0;
    fork
      engine();
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(gset_busy), 32'd0);
    check("rst_cmpt", 32'(gset_adc_cmpt), 32'd0);
    check("rst_err", 32'(gset_err), 32'd0);
    check("rst_valid", 32'(stx_valid), 32'd0);
    check("rst_data", 32'(stx_data), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < CHN; i++) d[i*CAP +: CAP] = 32'h00AB_CD00 + i;
    run(4'b1111, d, -1, 0, 0);

    d = rand_dac();
    d[2*CAP +: CAP] = 32'h0012_3456;
    run(4'b0100, d, -1, 0, 0);
    run(4'b0000, rand_dac(), CHN + 2, 0, 0);

    stall_at = 4;
    stall_rem = 5;
    run(4'b1111, rand_dac(), -1, 0, 0);
    check("stall_used", 32'(stall_rem), 32'd0);
    stall_at = -1;

    hold_busy = 1;
    run(4'b0011, rand_dac(), 2 + TMO, 1, 0);
    hold_busy = 0;
    run(4'b1111, rand_dac(), -1, 0, 0);

    run(4'b1011, rand_dac(), -1, 0, 1);

    d = rand_dac();
    build_exp(4'b1111, d);
    got.delete();
    stall_at = 4;
    stall_rem = 1000;
    start(4'b1111, d);
    n = 0;
    while (!(stx_valid && got.size() == 4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_ch1_b1", 32'(n < 100), 32'd1);
    check("ch1_b1_data", 32'(stx_data), 32'(exp_q[4]));
    #1 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(stx_valid), 32'd0);
    check("mid_rst_data", 32'(stx_data), 32'd0);
    check("mid_rst_busy", 32'(gset_busy), 32'd0);
    check("mid_rst_cmpt", 32'(gset_adc_cmpt), 32'd0);
    check("mid_rst_err", 32'(gset_err), 32'd0);
    stall_at = -1;
    stall_rem = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(4'b1111, d, -1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      run(4'($urandom_range(0, 15)), rand_dac(), -1, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
